// File: rtl/imem_loader_if.sv
// Loader bus: MSB-first byte stream in, instruction-memory
// write port out.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: packs big-endian words
// from a byte stream and holds the CPU until the program is in.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_WIDTH:0] word_count,
  imem_loader_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_CNT =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0] ONE =
    {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE, RECV, WRITE, DONE
  } state_e;

  state_e                state_q, state_d;
  logic [23:0]           asm_q, asm_d;
  logic [1:0]            bcnt_q, bcnt_d;
  logic [CW-1:0]         wcnt_q, wcnt_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  hold_q, hold_d;

  logic                  xfer;
  logic [CW-1:0]         clamp;
  logic [CW-1:0]         wnext;

  assign xfer  = bus.byte_valid && (state_q == RECV);
  assign clamp = (word_count > MAX_CNT) ? MAX_CNT
                                        : word_count;
  assign wnext = wcnt_q + ONE;

  always_comb begin
    state_d = state_q;
    asm_d   = asm_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = clamp;
          wcnt_d  = '0;
          bcnt_d  = '0;
          asm_d   = '0;
          hold_d  = 1'b1;
          state_d = (clamp == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (abort) begin
          state_d = IDLE;
          bcnt_d  = '0;
          asm_d   = '0;
        end else if (xfer) begin
          asm_d  = {asm_q[15:0], bus.byte_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = WRITE;
            we_d    = 1'b1;
            addr_d  = wcnt_q[ADDR_WIDTH-1:0];
            wdata_d = {asm_q, bus.byte_data};
          end
        end
      end
      WRITE: begin
        wcnt_d = wnext;
        if (abort) begin
          state_d = IDLE;
        end else if (wnext == cnt_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end else begin
          state_d = RECV;
        end
      end
      DONE: begin
        // Zero-word loads arrive here without a pulse yet.
        if (done_q) begin
          state_d = IDLE;
        end else begin
          done_d = 1'b1;
          hold_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      asm_q   <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.byte_ready = (state_q == RECV);
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy     = (state_q == RECV) || (state_q == WRITE);
  assign done     = done_q;
  assign cpu_hold = hold_q;
endmodule
